// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K x K 2-D correlation over one square 8-bit image.
// Pixels arrive two per beat in raster order. K-1 line buffers plus a K x K
// window feed a three-stage pipeline: multiply, row sums, total and clamp.
// Optional feature macro: CONV2D_RAW_SUM_EN. When it is defined, out_data
// carries the raw signed sum truncated to 16 bits instead of the clamped pixel.
//
// Input handshake: data_in_en is a registered request that toggles every
// cycle while the core is out of reset. A source that sees data_in_en=1 in
// cycle n may drive valid=1 with a beat in cycle n+1. Every cycle with valid=1
// transfers a beat, whatever data_in_en is doing in that cycle. There is no
// output backpressure: each out_valid pulse must be accepted by the sink.
module conv2d_stream #(
  parameter int IMG_SIZE    = 104,
  parameter int FILTER_SIZE = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [15:0]                            data,
  input  logic [FILTER_SIZE*FILTER_SIZE*8-1:0]   Fl,
  input  logic                                   valid,
  output logic                                   data_in_en,
  output logic [15:0]                            out_data,
  output logic                                   out_valid
);

  localparam int K       = FILTER_SIZE;
  localparam int KK      = K * K;
  localparam int LB_N    = (K > 1) ? K - 1 : 1;
  localparam int CW      = $clog2(IMG_SIZE);
  localparam int SW_CALC = 18 + $clog2(KK);
  localparam int SW      = (SW_CALC > 22) ? SW_CALC : 22;

  // Request, unpack and position state
  logic          r_in_en;
  logic [7:0]    r_hi;
  logic          r_hi_pend;
  logic [7:0]    r_pix;
  logic          r_pix_v;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Line buffers and sliding window (contents are never reset)
  logic [7:0]    r_lb  [LB_N][IMG_SIZE];
  logic [7:0]    r_win [K][K];
  logic          r_win_v;

  // Arithmetic pipeline
  logic signed [16:0] w_prod [KK];
  logic signed [16:0] r_prod [KK];
  logic               r_prod_v;
  logic [SW-1:0]      w_row_sum [K];
  logic [SW-1:0]      r_row_sum [K];
  logic               r_sum_v;
  logic [SW-1:0]      w_total;
  logic [15:0]        w_result;

  logic [15:0]   r_out_data;
  logic          r_out_v;

  // Column of K vertically aligned pixels ending at the current pixel:
  // w_col[i] is the pixel i rows above the incoming one.
  logic [7:0]    w_col [K];

  // Gather the current pixel and the matching line-buffer taps
  always_comb begin
    w_col[0] = r_pix;
    for (int i = 1; i < K; i++) begin
      w_col[i] = r_lb[i-1][r_col];
    end
  end

  // Input request toggle and beat unpacking (low byte first)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_en   <= 1'b0;
      r_hi      <= 8'd0;
      r_hi_pend <= 1'b0;
      r_pix     <= 8'd0;
      r_pix_v   <= 1'b0;
    end else begin
      r_in_en <= ~r_in_en;
      if (valid) begin
        r_pix     <= data[7:0];
        r_hi      <= data[15:8];
        r_pix_v   <= 1'b1;
        r_hi_pend <= 1'b1;
      end else if (r_hi_pend) begin
        r_pix     <= r_hi;
        r_pix_v   <= 1'b1;
        r_hi_pend <= 1'b0;
      end else begin
        r_pix_v   <= 1'b0;
      end
    end
  end

  // Row/column tracking and window-valid flag for each consumed pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_win_v <= 1'b0;
    end else if (r_pix_v) begin
      r_win_v <= (r_row >= CW'(K - 1)) && (r_col >= CW'(K - 1));
      if (r_col == CW'(IMG_SIZE - 1)) begin
        r_col <= '0;
        if (r_row == CW'(IMG_SIZE - 1)) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else begin
      r_win_v <= 1'b0;
    end
  end

  // Line-buffer writes and window shift; index [i][x]: i rows up, x columns left
  always_ff @(posedge clk) begin
    if (r_pix_v) begin
      for (int j = 0; j < K - 1; j++) begin
        r_lb[j][r_col] <= w_col[j];
      end
      for (int i = 0; i < K; i++) begin
        r_win[i][0] <= w_col[i];
        for (int x = 1; x < K; x++) begin
          r_win[i][x] <= r_win[i][x-1];
        end
      end
    end
  end

  // Products: Fl byte i*K+x weights window cell [i][x], so byte 0 is the
  // newest pixel and byte K*K-1 the top-left one (kernel in reading order)
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int x = 0; x < K; x++) begin
        w_prod[i*K+x] = $signed({9'd0, r_win[i][x]}) *
                        $signed({{9{Fl[8*(i*K+x)+7]}}, Fl[8*(i*K+x) +: 8]});
      end
    end
  end

  // Row sums of sign-extended products
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_row_sum[i] = '0;
      for (int x = 0; x < K; x++) begin
        w_row_sum[i] = w_row_sum[i] +
                       {{(SW-17){r_prod[i*K+x][16]}}, r_prod[i*K+x]};
      end
    end
  end

  // Final sum and result formatting
  always_comb begin
    w_total = '0;
    for (int i = 0; i < K; i++) begin
      w_total = w_total + r_row_sum[i];
    end
`ifdef CONV2D_RAW_SUM_EN
    w_result = w_total[15:0];
`else
    if (w_total[SW-1]) begin
      w_result = 16'd0;
    end else if (|w_total[SW-2:8]) begin
      w_result = 16'd255;
    end else begin
      w_result = {8'd0, w_total[7:0]};
    end
`endif
  end

  // Pipeline data registers (multiply stage, row-sum stage)
  always_ff @(posedge clk) begin
    for (int n = 0; n < KK; n++) begin
      r_prod[n] <= w_prod[n];
    end
    for (int i = 0; i < K; i++) begin
      r_row_sum[i] <= w_row_sum[i];
    end
  end

  // Pipeline valid bits and registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_v   <= 1'b0;
      r_sum_v    <= 1'b0;
      r_out_v    <= 1'b0;
      r_out_data <= 16'd0;
    end else begin
      r_prod_v <= r_win_v;
      r_sum_v  <= r_prod_v;
      r_out_v  <= r_sum_v;
      if (r_sum_v) begin
        r_out_data <= w_result;
      end
    end
  end

  assign data_in_en = r_in_en;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_v;

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: self-checking bench for conv2d_stream with two instances,
// a small one (8x8 image, 3x3 kernel) and the default one (104x104, 5x5).
// Expected results come from a direct reference correlation over the image.
module tb_conv2d_stream;

  localparam int NA = 8;
  localparam int KA = 3;
  localparam int NB = 104;
  localparam int KB = 5;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_a   = 1'b1;
  logic [15:0]            data_a  = '0;
  logic [KA*KA*8-1:0]     fl_a    = '0;
  logic                   valid_a = 1'b0;
  logic                   en_a;
  logic [15:0]            od_a;
  logic                   ov_a;

  logic                   rst_b   = 1'b1;
  logic [15:0]            data_b  = '0;
  logic [KB*KB*8-1:0]     fl_b    = '0;
  logic                   valid_b = 1'b0;
  logic                   en_b;
  logic [15:0]            od_b;
  logic                   ov_b;

  conv2d_stream #(.IMG_SIZE(NA), .FILTER_SIZE(KA)) dut_a (
    .clk(clk), .rst(rst_a), .data(data_a), .Fl(fl_a), .valid(valid_a),
    .data_in_en(en_a), .out_data(od_a), .out_valid(ov_a)
  );

  conv2d_stream #(.IMG_SIZE(NB), .FILTER_SIZE(KB)) dut_b (
    .clk(clk), .rst(rst_b), .data(data_b), .Fl(fl_b), .valid(valid_b),
    .data_in_en(en_b), .out_data(od_b), .out_valid(ov_b)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic [7:0]  img [NB][NB];
  int          kern [25];

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitors: pop the scoreboard on every pulse
  always @(negedge clk) begin
    if (!rst_a && ov_a) begin
      cnt_a++;
      if (exp_q_a.size() == 0) check_eq("a_unexpected", 16'(exp_q_a.size()), 16'd1);
      else check_eq("a_out", od_a, exp_q_a.pop_front());
    end
    if (!rst_b && ov_b) begin
      cnt_b++;
      if (exp_q_b.size() == 0) check_eq("b_unexpected", 16'(exp_q_b.size()), 16'd1);
      else check_eq("b_out", od_b, exp_q_b.pop_front());
    end
  end

  // Reference correlation for the first 'rows' rows of img
  task automatic model(input int n, input int k, input int rows, input bit to_b);
    int sum;
    logic [15:0] e;
    for (int r = k - 1; r < rows; r++) begin
      for (int c = k - 1; c < n; c++) begin
        sum = 0;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            sum += int'(img[r-k+1+i][c-k+1+j]) * kern[i*k+j];
`ifdef CONV2D_RAW_SUM_EN
        e = 16'(sum);
`else
        e = (sum < 0) ? 16'd0 : (sum > 255) ? 16'd255 : 16'(sum);
`endif
        if (to_b) exp_q_b.push_back(e);
        else exp_q_a.push_back(e);
      end
    end
  endtask

  // kern[] is in reading order; reading index 0 lands in the top byte
  task automatic set_kernel(input int k, input bit to_b);
    for (int idx = 0; idx < k * k; idx++) begin
      if (to_b) fl_b[8*(k*k-1-idx) +: 8] = 8'(kern[idx]);
      else fl_a[8*(k*k-1-idx) +: 8] = 8'(kern[idx]);
    end
  endtask

  // Driver: wait for the request, then present the beat the next cycle
  task automatic send_beat(input logic [15:0] d, input bit to_b);
    int guard = 0;
    while (!(to_b ? en_b : en_a) && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 10) check_eq("en_timeout", 16'(to_b ? en_b : en_a), 16'd1);
    @(posedge clk); #1;
    if (to_b) begin valid_b = 1'b1; data_b = d; end
    else begin valid_a = 1'b1; data_a = d; end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic send_frame(input int n, input int rows, input bit to_b);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < n; c += 2)
        send_beat({img[r][c+1], img[r][c]}, to_b);
  endtask

  task automatic wait_drain(input bit to_b);
    int guard = 0;
    while ((to_b ? exp_q_b.size() : exp_q_a.size()) > 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (6) @(posedge clk);
    #1;
    check_eq(to_b ? "b_drain" : "a_drain",
             16'(to_b ? exp_q_b.size() : exp_q_a.size()), 16'd0);
  endtask

  // One full frame with output-count check
  task automatic run_frame(input int n, input int k, input bit to_b, input string tag);
    int base;
    base = to_b ? cnt_b : cnt_a;
    model(n, k, n, to_b);
    send_frame(n, n, to_b);
    wait_drain(to_b);
    check_eq(tag, 16'((to_b ? cnt_b : cnt_a) - base), 16'((n - k + 1) * (n - k + 1)));
  endtask

  // Main sequence
  initial begin
    int base;
    // Reset hold with valid toggling
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid_a = ~valid_a;
      data_a  = 16'($urandom_range(0, 65535));
      check_eq("rst_out_valid", {15'd0, ov_a}, 16'd0);
      check_eq("rst_in_en", {15'd0, en_a}, 16'd0);
      check_eq("rst_out_data", od_a, 16'd0);
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    rst_a   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("en_pattern", {15'd0, en_a}, (i % 2 == 0) ? 16'd1 : 16'd0);
    end

    // Identity kernel, pixel = 8r+c
    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 1 : 0;
    set_kernel(KA, 1'b0);
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'(8 * r + c);
    run_frame(NA, KA, 1'b0, "a_count_identity");

    // All-ones kernel on flat images: saturating and in-range
    for (int i = 0; i < 9; i++) kern[i] = 1;
    set_kernel(KA, 1'b0);
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'd30;
    run_frame(NA, KA, 1'b0, "a_count_ones30");
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'd20;
    run_frame(NA, KA, 1'b0, "a_count_ones20");

    // Negative centre weight
    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? -1 : 0;
    set_kernel(KA, 1'b0);
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'd50;
    run_frame(NA, KA, 1'b0, "a_count_neg");

    // Only the MSB byte set: selects the top-left pixel
    for (int i = 0; i < 9; i++) kern[i] = (i == 0) ? 1 : 0;
    set_kernel(KA, 1'b0);
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'(8 * r + c);
    run_frame(NA, KA, 1'b0, "a_count_msb");

    // Mixed random kernel and image on the small instance
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 40)) - 20;
    set_kernel(KA, 1'b0);
    for (int r = 0; r < NA; r++) for (int c = 0; c < NA; c++) img[r][c] = 8'($urandom_range(0, 255));
    run_frame(NA, KA, 1'b0, "a_count_rand");

    // Full-size instance: random kernel, two back-to-back frames
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int i = 0; i < 25; i++) kern[i] = int'($urandom_range(0, 8)) - 4;
    set_kernel(KB, 1'b1);
    for (int r = 0; r < NB; r++) for (int c = 0; c < NB; c++) img[r][c] = 8'($urandom_range(0, 255));
    base = cnt_b;
    model(NB, KB, NB, 1'b1);
    model(NB, KB, NB, 1'b1);
    send_frame(NB, NB, 1'b1);
    send_frame(NB, NB, 1'b1);
    wait_drain(1'b1);
    check_eq("b_count_two_frames", 16'(cnt_b - base), 16'd20000);

    // Partial frame, reset, then a complete frame
    base = cnt_b;
    model(NB, KB, 30, 1'b1);
    send_frame(NB, 30, 1'b1);
    wait_drain(1'b1);
    check_eq("b_count_partial", 16'(cnt_b - base), 16'(26 * 100));
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    run_frame(NB, KB, 1'b1, "b_count_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
